// File: rtl/fixed_mult_if.sv
// fixed_mult_if: operand/result stream bundle for fixed_mult_pipe.
// The master drives operands and out_ready; the slave (the multiplier) drives results and in_ready.
interface fixed_mult_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_round;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_round, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_round, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fixed_mult_pipe.sv
// fixed_mult_pipe: pipelined signed fixed-point multiplier with truncate/round modes and overflow flag.
// Define FIXED_MULT_SAT_EN to clamp overflowing results; otherwise results wrap.
module fixed_mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int STAGES = 3
) (
    input logic        clk,
    input logic        rst,
    fixed_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int NF = (STAGES >= 3) ? STAGES - 2 : 1;
    localparam logic [PW-1:0] LIM = PW'(1) << (WIDTH - 1);
    localparam logic [PW-1:0] RND = PW'(1) << (FRAC - 1);

    logic              adv;
    logic [STAGES-1:0] v;
    logic              sign_c;
    logic [WIDTH-1:0]  ma_c;
    logic [WIDTH-1:0]  mb_c;
    logic              p_sign;
    logic              p_round;
    logic [PW-1:0]     p_prod;
    logic [PW-1:0]     shifted;
    logic              ovf_c;
    logic [WIDTH-1:0]  wrap_c;
    logic [WIDTH-1:0]  fin_c;
    logic [WIDTH-1:0]  fd [NF];
    logic [NF-1:0]     fo;

    assign adv           = !v[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = fd[NF-1];
    assign bus.out_ovf   = fo[NF-1];

    // Unsigned magnitudes: the most-negative operand maps to 2^(WIDTH-1) exactly.
    assign sign_c = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
    assign ma_c   = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    assign mb_c   = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;

    generate
        if (STAGES >= 3) begin : g_deep
            logic             s1, r1, s2, r2;
            logic [WIDTH-1:0] a1, b1;
            logic [PW-1:0]    pr2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1  <= 1'b0;
                    r1  <= 1'b0;
                    a1  <= '0;
                    b1  <= '0;
                    s2  <= 1'b0;
                    r2  <= 1'b0;
                    pr2 <= '0;
                end else if (adv) begin
                    s1  <= sign_c;
                    r1  <= bus.in_round;
                    a1  <= ma_c;
                    b1  <= mb_c;
                    s2  <= s1;
                    r2  <= r1;
                    pr2 <= {{WIDTH{1'b0}}, a1} * {{WIDTH{1'b0}}, b1};
                end
            end
            assign p_sign  = s2;
            assign p_round = r2;
            assign p_prod  = pr2;
        end else if (STAGES == 2) begin : g_two
            logic             s1, r1;
            logic [WIDTH-1:0] a1, b1;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1 <= 1'b0;
                    r1 <= 1'b0;
                    a1 <= '0;
                    b1 <= '0;
                end else if (adv) begin
                    s1 <= sign_c;
                    r1 <= bus.in_round;
                    a1 <= ma_c;
                    b1 <= mb_c;
                end
            end
            assign p_sign  = s1;
            assign p_round = r1;
            assign p_prod  = {{WIDTH{1'b0}}, a1} * {{WIDTH{1'b0}}, b1};
        end else begin : g_one
            assign p_sign  = sign_c;
            assign p_round = bus.in_round;
            assign p_prod  = {{WIDTH{1'b0}}, ma_c} * {{WIDTH{1'b0}}, mb_c};
        end
    endgenerate

    // Negative results may reach one unit further than positive ones.
    assign shifted = (p_prod + (p_round ? RND : '0)) >> FRAC;
    assign ovf_c   = p_sign ? (shifted > LIM) : (shifted >= LIM);
    assign wrap_c  = p_sign ? -shifted[WIDTH-1:0] : shifted[WIDTH-1:0];

`ifdef FIXED_MULT_SAT_EN
    assign fin_c = !ovf_c ? wrap_c : p_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign fin_c = wrap_c;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v  <= '0;
            fo <= '0;
            for (int i = 0; i < NF; i++) fd[i] <= '0;
        end else if (adv) begin
            v[0]  <= bus.in_valid;
            for (int i = 1; i < STAGES; i++) v[i] <= v[i-1];
            fd[0] <= fin_c;
            fo[0] <= ovf_c;
            for (int i = 1; i < NF; i++) begin
                fd[i] <= fd[i-1];
                fo[i] <= fo[i-1];
            end
        end
    end
endmodule
